// File: rtl/config_port_arbiter.sv
// config_port_arbiter: shares the single command port of the flash-backed
// configuration register between requester A (host endpoint) and requester B
// (internal sequencer). One command at a time: latch the command, pulse the
// trigger once, then hold the buses stable for a per-opcode wait, because the
// config block has no busy flag.
// Build option: define CFG_ARB_FIXED_PRIO_EN to make A win every tie.
// When it is undefined (the default), ties alternate round-robin.
module config_port_arbiter #(
  parameter logic [31:0] GET_WAIT  = 32'd128,
  parameter logic [31:0] SET_WAIT  = 32'd128,
  parameter logic [31:0] LOAD_WAIT = 32'd1_000_000,
  parameter logic [31:0] SAVE_WAIT = 32'd400_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        a_req_in,
  input  logic [15:0] a_addr_in,
  input  logic [15:0] a_data1_in,
  input  logic [15:0] a_data2_in,
  output logic        a_ack_out,
  output logic        a_err_out,
  output logic [15:0] a_data_out,
  input  logic        b_req_in,
  input  logic [15:0] b_addr_in,
  input  logic [15:0] b_data1_in,
  input  logic [15:0] b_data2_in,
  output logic        b_ack_out,
  output logic        b_err_out,
  output logic [15:0] b_data_out,
  output logic        cfg_trig_out,
  output logic [15:0] cfg_addr_out,
  output logic [15:0] cfg_data1_out,
  output logic [15:0] cfg_data2_out,
  input  logic [15:0] cfg_data_in,
  output logic        busy_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        grant_b;
  logic        pick_b;
  logic        err_flag;
  logic        capture;
  logic [31:0] wait_cnt;
  logic [31:0] wait_load;
  logic [15:0] sel_addr;
  logic [15:0] sel_data1;
  logic [15:0] sel_data2;
  logic [7:0]  sel_op;
  logic [15:0] cfg_addr;
  logic [15:0] cfg_data1;
  logic [15:0] cfg_data2;
  logic [15:0] a_data;
  logic [15:0] b_data;
`ifndef CFG_ARB_FIXED_PRIO_EN
  logic        last_grant_b;
`endif

  // Choose who wins the next grant when leaving IDLE.
  always_comb begin
    pick_b = 1'b0;
`ifdef CFG_ARB_FIXED_PRIO_EN
    pick_b = !a_req_in;
`else
    pick_b = b_req_in && (!a_req_in || !last_grant_b);
`endif
  end

  // Route the winner's command fields and pick its hold time (zero counts as one).
  always_comb begin
    sel_addr  = grant_b ? b_addr_in  : a_addr_in;
    sel_data1 = grant_b ? b_data1_in : a_data1_in;
    sel_data2 = grant_b ? b_data2_in : a_data2_in;
    sel_op    = sel_addr[15:8];
    case (sel_op)
      8'h00:   wait_load = GET_WAIT;
      8'h01:   wait_load = SET_WAIT;
      8'h02:   wait_load = LOAD_WAIT;
      default: wait_load = SAVE_WAIT;
    endcase
    if (wait_load == 32'd0) begin
      wait_load = 32'd1;
    end
  end

  // Next-state logic for the command sequencer.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (a_req_in || b_req_in) next_state = ST_GRANT;
      ST_GRANT: next_state = (sel_op > 8'h03) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT:  if (wait_cnt <= 32'd1) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Read data is sampled on the final hold cycle of a get.
  assign capture = (state == ST_WAIT) && (wait_cnt <= 32'd1) && (cfg_addr[15:8] == 8'h00);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Remember the current winner; the fairness pointer moves only on completion.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      grant_b <= 1'b0;
`ifndef CFG_ARB_FIXED_PRIO_EN
      last_grant_b <= 1'b1;
`endif
    end else begin
      if (state == ST_IDLE && (a_req_in || b_req_in)) begin
        grant_b <= pick_b;
      end
`ifndef CFG_ARB_FIXED_PRIO_EN
      if (state == ST_DONE) begin
        last_grant_b <= grant_b;
      end
`endif
    end
  end

  // Latch the command buses at grant; they stay frozen until the next grant.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cfg_addr  <= 16'h0000;
      cfg_data1 <= 16'h0000;
      cfg_data2 <= 16'h0000;
      err_flag  <= 1'b0;
    end else if (state == ST_GRANT) begin
      cfg_addr  <= sel_addr;
      cfg_data1 <= sel_data1;
      cfg_data2 <= sel_data2;
      err_flag  <= (sel_op > 8'h03);
    end
  end

  // Hold-time counter: loaded at grant, counts down in WAIT and stops at one.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wait_cnt <= 32'd0;
    end else if (state == ST_GRANT) begin
      wait_cnt <= wait_load;
    end else if (state == ST_WAIT && wait_cnt > 32'd1) begin
      wait_cnt <= wait_cnt - 32'd1;
    end
  end

  // Per-requester read data; only the winner of a get is updated.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_data <= 16'h0000;
      b_data <= 16'h0000;
    end else if (capture) begin
      if (grant_b) begin
        b_data <= cfg_data_in;
      end else begin
        a_data <= cfg_data_in;
      end
    end
  end

  assign cfg_trig_out  = (state == ST_ISSUE);
  assign cfg_addr_out  = cfg_addr;
  assign cfg_data1_out = cfg_data1;
  assign cfg_data2_out = cfg_data2;
  assign busy_out      = (state != ST_IDLE);
  assign a_ack_out     = (state == ST_DONE) && !grant_b;
  assign b_ack_out     = (state == ST_DONE) && grant_b;
  assign a_err_out     = a_ack_out && err_flag;
  assign b_err_out     = b_ack_out && err_flag;
  assign a_data_out    = a_data;
  assign b_data_out    = b_data;

endmodule

// File: tb/tb_config_port_arbiter.sv
// tb_config_port_arbiter: directed vectors for config_port_arbiter with short
// hold times, a small behavioural config-register memory, and hand-written
// sequences for ties, round-robin, long saves and reset during a command.
`timescale 1ns/1ps
module tb_config_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        a_req_in, b_req_in;
  logic [15:0] a_addr_in, a_data1_in, a_data2_in;
  logic [15:0] b_addr_in, b_data1_in, b_data2_in;
  logic        a_ack_out, a_err_out, b_ack_out, b_err_out;
  logic [15:0] a_data_out, b_data_out;
  logic        cfg_trig_out, busy_out;
  logic [15:0] cfg_addr_out, cfg_data1_out, cfg_data2_out, cfg_data_in;

  int checks = 0;
  int errors = 0;

  config_port_arbiter #(
    .GET_WAIT (32'd4),
    .SET_WAIT (32'd4),
    .LOAD_WAIT(32'd20),
    .SAVE_WAIT(32'd50)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .a_req_in     (a_req_in),
    .a_addr_in    (a_addr_in),
    .a_data1_in   (a_data1_in),
    .a_data2_in   (a_data2_in),
    .a_ack_out    (a_ack_out),
    .a_err_out    (a_err_out),
    .a_data_out   (a_data_out),
    .b_req_in     (b_req_in),
    .b_addr_in    (b_addr_in),
    .b_data1_in   (b_data1_in),
    .b_data2_in   (b_data2_in),
    .b_ack_out    (b_ack_out),
    .b_err_out    (b_err_out),
    .b_data_out   (b_data_out),
    .cfg_trig_out (cfg_trig_out),
    .cfg_addr_out (cfg_addr_out),
    .cfg_data1_out(cfg_data1_out),
    .cfg_data2_out(cfg_data2_out),
    .cfg_data_in  (cfg_data_in),
    .busy_out     (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural config register: a set writes word data1, reads return word data1.
  logic [15:0] cfg_mem [16];
  initial for (int i = 0; i < 16; i++) cfg_mem[i] = 16'h0000;
  always @(posedge clk_in) begin
    if (cfg_trig_out && cfg_addr_out[15:8] == 8'h01) cfg_mem[cfg_data1_out[3:0]] <= cfg_data2_out;
  end
  assign cfg_data_in = cfg_mem[cfg_data1_out[3:0]];

  typedef struct {
    bit          use_b;
    logic [15:0] addr;
    logic [15:0] d1;
    logic [15:0] d2;
    int          lat;
    int          trigs;
    bit          err;
    logic [15:0] a_data;
    logic [15:0] b_data;
  } vec_t;

  vec_t vecs[9];

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_in   = 1'b1;
    a_req_in = 1'b0;
    b_req_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Drive one command from one requester and check the whole transaction.
  task automatic applyStimulus(input int idx, input vec_t v);
    int          cyc;
    int          trigs;
    bit          seen_ack;
    bit          stable;
    bit          foreign;
    bit          snapped;
    bit          got_err;
    bit          busy_at_ack;
    logic [47:0] snap;
    @(negedge clk_in);
    if (v.use_b) begin
      b_req_in = 1'b1; b_addr_in = v.addr; b_data1_in = v.d1; b_data2_in = v.d2;
    end else begin
      a_req_in = 1'b1; a_addr_in = v.addr; a_data1_in = v.d1; a_data2_in = v.d2;
    end
    cyc = 0; trigs = 0; seen_ack = 0; stable = 1; foreign = 0; snapped = 0; got_err = 0;
    busy_at_ack = 0; snap = '0;
    while (!seen_ack && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      if (snapped && {cfg_addr_out, cfg_data1_out, cfg_data2_out} !== snap) stable = 0;
      if (cfg_trig_out) begin
        trigs++;
        snap    = {cfg_addr_out, cfg_data1_out, cfg_data2_out};
        snapped = 1;
      end
      if (v.use_b ? a_ack_out : b_ack_out) foreign = 1;
      if (v.use_b ? b_ack_out : a_ack_out) begin
        seen_ack    = 1;
        got_err     = v.use_b ? b_err_out : a_err_out;
        busy_at_ack = busy_out;
        a_req_in    = 1'b0;
        b_req_in    = 1'b0;
      end
    end
    checkOutput($sformatf("v%0d_latency", idx), cyc, v.lat);
    checkOutput($sformatf("v%0d_trig_count", idx), trigs, v.trigs);
    checkOutput($sformatf("v%0d_err", idx), got_err, v.err);
    checkOutput($sformatf("v%0d_cfg_stable", idx), stable, 1);
    checkOutput($sformatf("v%0d_foreign_ack", idx), foreign, 0);
    checkOutput($sformatf("v%0d_busy_at_ack", idx), busy_at_ack, 1);
    checkOutput($sformatf("v%0d_cfg_bus", idx), {cfg_addr_out, cfg_data1_out, cfg_data2_out},
                {v.addr, v.d1, v.d2});
    checkOutput($sformatf("v%0d_a_data", idx), a_data_out, v.a_data);
    checkOutput($sformatf("v%0d_b_data", idx), b_data_out, v.b_data);
  endtask

  initial begin
    int  cyc;
    int  a_at;
    int  b_at;
    int  busy_cnt;
    int  trigs;
    int  n_acks;
    bit  order[4];
    bit  exp_order[4];
    bit  early_ack;

    a_addr_in = '0; a_data1_in = '0; a_data2_in = '0;
    b_addr_in = '0; b_data1_in = '0; b_data2_in = '0;

    // use_b, addr, d1, d2, latency, trigs, err, a_data, b_data
    vecs[0] = '{0, 16'h0100, 16'd3, 16'hBEEF,  7, 1, 0, 16'h0000, 16'h0000};
    vecs[1] = '{0, 16'h0000, 16'd3, 16'h0000,  7, 1, 0, 16'hBEEF, 16'h0000};
    vecs[2] = '{1, 16'h0105, 16'd5, 16'h1234,  7, 1, 0, 16'hBEEF, 16'h0000};
    vecs[3] = '{1, 16'h0000, 16'd5, 16'h0000,  7, 1, 0, 16'hBEEF, 16'h1234};
    vecs[4] = '{0, 16'h0200, 16'd0, 16'h0000, 23, 1, 0, 16'hBEEF, 16'h1234};
    vecs[5] = '{0, 16'h0700, 16'd1, 16'h0000,  2, 0, 1, 16'hBEEF, 16'h1234};
    vecs[6] = '{1, 16'hFF00, 16'd2, 16'h0000,  2, 0, 1, 16'hBEEF, 16'h1234};
    vecs[7] = '{0, 16'h0000, 16'd5, 16'h0000,  7, 1, 0, 16'h1234, 16'h1234};
    vecs[8] = '{1, 16'h0000, 16'd9, 16'h0000,  7, 1, 0, 16'h1234, 16'h0000};

    doReset();
    checkOutput("reset_ctrl", {a_ack_out, a_err_out, b_ack_out, b_err_out, cfg_trig_out, busy_out}, 0);
    checkOutput("reset_data", {a_data_out, b_data_out, cfg_addr_out, cfg_data1_out, cfg_data2_out}, 0);

    for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

    // Both request in the same cycle after reset: A first, then B.
    doReset();
    @(negedge clk_in);
    a_req_in = 1; a_addr_in = 16'h0100; a_data1_in = 16'd1; a_data2_in = 16'h1111;
    b_req_in = 1; b_addr_in = 16'h0100; b_data1_in = 16'd2; b_data2_in = 16'h2222;
    cyc = 0; a_at = 0; b_at = 0;
    while ((a_at == 0 || b_at == 0) && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
      if (a_ack_out && a_at == 0) begin a_at = cyc; a_req_in = 0; end
      if (b_ack_out && b_at == 0) begin b_at = cyc; b_req_in = 0; end
    end
    checkOutput("tie_a_ack_cycle", a_at, 7);
    checkOutput("tie_b_ack_cycle", b_at, 15);

    // Both held for four commands: round-robin alternates, fixed priority keeps A.
`ifdef CFG_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    doReset();
    @(negedge clk_in);
    a_req_in = 1; b_req_in = 1;
    cyc = 0; n_acks = 0;
    while (n_acks < 4 && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      if (a_ack_out || b_ack_out) begin
        order[n_acks] = b_ack_out;
        n_acks++;
      end
    end
    a_req_in = 0; b_req_in = 0;
    checkOutput("hold_ack_count", n_acks, 4);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("hold_grant%0d_is_b", k), order[k], exp_order[k]);

    // Long save from B; A arrives mid-save and must wait for b_ack.
    doReset();
    @(negedge clk_in);
    b_req_in = 1; b_addr_in = 16'h0300; b_data1_in = 16'd0; b_data2_in = 16'h0000;
    cyc = 0; a_at = 0; b_at = 0; busy_cnt = 0; trigs = 0;
    while (a_at == 0 && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      if (b_at == 0 && busy_out) busy_cnt++;
      if (b_at == 0 && cfg_trig_out) trigs++;
      if (cyc == 10) begin
        a_req_in = 1; a_addr_in = 16'h0100; a_data1_in = 16'd7; a_data2_in = 16'h7777;
      end
      if (b_ack_out && b_at == 0) begin b_at = cyc; b_req_in = 0; end
      if (a_ack_out) begin a_at = cyc; a_req_in = 0; end
    end
    checkOutput("save_b_ack_cycle", b_at, 53);
    checkOutput("save_busy_cycles", busy_cnt, 53);
    checkOutput("save_trig_count", trigs, 1);
    checkOutput("save_a_ack_cycle", a_at, 61);

    // Reset pulsed in the middle of a load: no ack, everything cleared, A re-served.
    doReset();
    @(negedge clk_in);
    a_req_in = 1; a_addr_in = 16'h0200; a_data1_in = 16'd0; a_data2_in = 16'h0000;
    early_ack = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (a_ack_out || b_ack_out) early_ack = 1;
    end
    rst_in = 1;
    #1;
    checkOutput("midrst_ctrl", {a_ack_out, a_err_out, b_ack_out, b_err_out, cfg_trig_out, busy_out}, 0);
    checkOutput("midrst_data", {a_data_out, b_data_out, cfg_addr_out, cfg_data1_out, cfg_data2_out}, 0);
    repeat (2) begin
      @(negedge clk_in);
      if (a_ack_out || b_ack_out) early_ack = 1;
    end
    rst_in = 0;
    checkOutput("midrst_no_ack", early_ack, 0);
    cyc = 0; a_at = 0; trigs = 0;
    while (a_at == 0 && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      if (cfg_trig_out) trigs++;
      if (a_ack_out) begin a_at = cyc; a_req_in = 0; end
    end
    checkOutput("midrst_reserve_ack_cycle", a_at, 23);
    checkOutput("midrst_reserve_trig", trigs, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
